// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the 16x oversampling UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int OS_RATE         = 16;
  localparam int OS_MID          = 7;
  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous single-bit inputs
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampling UART receiver, 8N1 by default
// Define UART_RX_PARITY_EN to insert a parity bit between data and stop.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DBIT       = DBIT_DEFAULT,
  parameter int SB_TICK    = SB_TICK_DEFAULT,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  // s_cnt must reach both OS_RATE-1 (data bits) and SB_TICK-1 (stop bit)
  localparam int SW = ($clog2(SB_TICK) > $clog2(OS_RATE)) ? $clog2(SB_TICK) : $clog2(OS_RATE);
  localparam int NW = ($clog2(DBIT) > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(OS_MID);
  localparam logic [SW-1:0] S_LAST = SW'(OS_RATE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  rx_state_e       state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (s_tick && s_cnt_q == S_MID) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (s_tick && s_cnt_q == S_LAST && n_cnt_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick && s_cnt_q == S_LAST) state_d = STOP;
      end
`endif
      STOP: begin
        if (s_tick && s_cnt_q == S_STOP) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_q, perr_d;
`endif

  always_comb begin
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) s_cnt_d = '0;
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == S_MID) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            shreg_d = {rx_s, shreg_q[DBIT-1:1]};
            if (n_cnt_q != N_LAST) n_cnt_d = n_cnt_q + 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d   = '0;
            par_bad_d = (^shreg_q) ^ rx_s ^ (PARITY_ODD != 0);
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == S_STOP) begin
            s_cnt_d = '0;
            done_d  = 1'b1;
            dout_d  = shreg_q;
            ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
  assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb/tb_uart_rx_os16.sv - directed frames checked against a frame-queue model every cycle
// Parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os16;

  localparam int BIT_CLK = 64;
  localparam int PODD    = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  exp_t       q[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_fe = 1'b0;
  logic       m_pe = 1'b0;
  int         pulses = 0;
  int         tests = 0;
  int         fails = 0;

  uart_rx_os16 #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(PODD)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    int tcnt;
    tcnt = 0;
    forever begin
      @(negedge clk);
      tcnt   = (tcnt + 1) % 4;
      s_tick = (tcnt == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each frame the bench drives is queued with the values it must deliver
  task automatic compare_loop();
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        q.delete();
        m_dout = 8'h00;
        m_fe   = 1'b0;
        m_pe   = 1'b0;
        check("done_in_reset", {31'd0, rx_done_tick}, 32'd0);
      end else begin
        check("unexpected_pulse", {31'd0, rx_done_tick && (q.size() == 0)}, 32'd0);
        if (rx_done_tick && q.size() > 0) begin
          pulses++;
          e      = q.pop_front();
          m_dout = e.d;
          m_fe   = e.fe;
          m_pe   = e.pe;
        end
      end
      check("dout", {24'd0, dout}, {24'd0, m_dout});
      check("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
      check("parity_err", {31'd0, parity_err}, {31'd0, m_pe});
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input logic par,
                            input int abort_at);
    exp_t e;
    e.d  = d;
    e.fe = ~stop_lvl;
    e.pe = HAS_PAR ? ((^d) ^ par ^ PODD[0]) : 1'b0;
    q.push_back(e);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == abort_at) begin
        repeat (BIT_CLK / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_done", {31'd0, rx_done_tick}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_perr", {31'd0, parity_err}, 32'd0);
        reset = 1'b0;
        rx    = 1'b1;
        return;
      end
      repeat (BIT_CLK) @(negedge clk);
    end
    if (HAS_PAR) begin
      rx = par;
      repeat (BIT_CLK) @(negedge clk);
    end
    if (stop_lvl) begin
      rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end else begin
      // Low stop bit releases before the receiver could take it for a new start bit
      rx = 1'b0;
      repeat (40) @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CLK - 40) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_drained(input string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, q.size(), 32'd0);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  initial begin
    fork
      compare_loop();
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (4) @(negedge clk);
    check("reset_dout", {24'd0, dout}, 32'd0);
    check("reset_done", {31'd0, rx_done_tick}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    check("reset_perr", {31'd0, parity_err}, 32'd0);
    reset = 1'b0;
    idle(20);

    send_frame(8'hA5, 1'b1, even_par(8'hA5), -1);
    idle(BIT_CLK);
    wait_drained("drain_a5");
    check("a5_dout", {24'd0, dout}, 32'hA5);
    check("a5_ferr", {31'd0, frame_err}, 32'd0);
    check("a5_perr", {31'd0, parity_err}, 32'd0);
    check("a5_pulses", pulses, 32'd1);

    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle(200);
    check("glitch_pulses", pulses, 32'd1);
    check("glitch_dout", {24'd0, dout}, 32'hA5);

    send_frame(8'h3C, 1'b0, even_par(8'h3C), -1);
    idle(BIT_CLK);
    wait_drained("drain_3c");
    check("3c_dout", {24'd0, dout}, 32'h3C);
    check("3c_ferr", {31'd0, frame_err}, 32'd1);
    send_frame(8'h01, 1'b1, even_par(8'h01), -1);
    idle(BIT_CLK);
    wait_drained("drain_01");
    check("01_dout", {24'd0, dout}, 32'h01);
    check("01_ferr", {31'd0, frame_err}, 32'd0);
    check("01_pulses", pulses, 32'd3);

    send_frame(8'h00, 1'b1, even_par(8'h00), -1);
    send_frame(8'hFF, 1'b1, even_par(8'hFF), -1);
    idle(BIT_CLK);
    wait_drained("drain_b2b");
    check("b2b_dout", {24'd0, dout}, 32'hFF);
    check("b2b_pulses", pulses, 32'd5);

    send_frame(8'h77, 1'b1, even_par(8'h77), 3);
    idle(3 * BIT_CLK);
    check("abort_pulses", pulses, 32'd5);
    send_frame(8'h5A, 1'b1, even_par(8'h5A), -1);
    idle(BIT_CLK);
    wait_drained("drain_5a");
    check("5a_dout", {24'd0, dout}, 32'h5A);
    check("5a_pulses", pulses, 32'd6);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, -1);
    idle(BIT_CLK);
    wait_drained("drain_par0");
    check("par0_perr", {31'd0, parity_err}, 32'd1);
    check("par0_dout", {24'd0, dout}, 32'h07);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    idle(BIT_CLK);
    wait_drained("drain_par1");
    check("par1_perr", {31'd0, parity_err}, 32'd0);
    check("par_pulses", pulses, 32'd8);
`endif

    idle(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- UART receiver, 8N1 by default, with 16x oversampling.
- Consumes the single-cycle `s_tick` pulse from the baud tick counter. That pulse runs at 16x the baud rate, e.g. 100 MHz / (16·9600).
- Recovers serial bytes from the `rx` pin and presents each one with a one-cycle done strobe.
- Sits between the board pin and the FPU command/operand assembly logic; it is the receive end paired with the baud tick generator.

Parameters:
- DBIT, 8, number of data bits per frame, LSB first.
- SB_TICK, 16, oversample ticks per stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY_ODD, 0, parity sense used only when the optional feature is compiled in; 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idle level is high.
- s_tick  input  1  one-cycle pulse at 16x baud, from the baud tick counter.
- dout  output  DBIT  last received byte; held until the next frame completes.
- rx_done_tick  output  1  one-cycle pulse; `dout` is valid in the same cycle.
- frame_err  output  1  stop bit was sampled low in the last frame; updated with `rx_done_tick`.
- parity_err  output  1  parity mismatch in the last frame; constant 0 without the feature.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high. If `reset` and any other event occur in the same cycle, reset wins.
- Reset values:
  - state = IDLE; s_cnt = 0; n_cnt = 0; shift register = 0.
  - dout = 0; rx_done_tick = 0; frame_err = 0; parity_err = 0.
  - Synchronizer flops = 1.
- Input sync: `rx` passes through a 2-flop synchronizer giving `rx_s`. It adds 2 clk of latency and is reset to 1.
- Counter widths: s_cnt is wide enough for SB_TICK-1; n_cnt is clog2(DBIT) bits.
- Tick gating: s_cnt and n_cnt change only in cycles where s_tick = 1, except for the IDLE exit, which does not wait for a tick.
- IDLE:
  - rx_s = 0 → go to START, s_cnt = 0.
- START:
  - On a tick with s_cnt == 7 (mid start bit):
    - rx_s = 0 → go to DATA, s_cnt = 0, n_cnt = 0.
    - rx_s = 1 → go to IDLE. The glitch is rejected: no strobe, no flag change.
  - On any other tick: s_cnt++.
- DATA:
  - On a tick with s_cnt == 15:
    - s_cnt = 0; shift in with shreg = {rx_s, shreg[DBIT-1:1]}.
    - If n_cnt == DBIT-1 → go to STOP (or PARITY when the feature is enabled); otherwise n_cnt++.
  - On any other tick: s_cnt++.
- STOP:
  - On a tick with s_cnt == SB_TICK-1: go to IDLE.
    - Registered outputs in the next cycle: rx_done_tick = 1 for exactly one clk, dout = shreg, frame_err = ~rx_s.
  - On any other tick: s_cnt++.
- Framing errors: the frame is still delivered; only frame_err flags it.
- Back-to-back frames: a start edge that appears in the cycle after the STOP exit is accepted. There is no dead time.
- Mid-frame reset: any state returns to IDLE and all outputs return to their reset values. A frame in progress is discarded.
- `s_tick` stuck high: legal. The block then oversamples at the clk rate.

Optional Feature:
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - On a tick with s_cnt == 15, the parity bit p = rx_s is sampled.
  - parity_err = (^shreg) ^ p ^ PARITY_ODD, updated together with rx_done_tick.
- Undefined:
  - The PARITY state is absent.
  - parity_err is tied to 0.
  - Frame length is 1 + DBIT + stop.

Decomposition:
- Package `uart_pkg`:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Constants: OS_RATE = 16, OS_MID = 7.
  - Default DBIT and SB_TICK values.
- Sub-module `sync_2ff`:
  - Generic 2-flop synchronizer with a reset value parameter.
  - Reused for any other asynchronous pins.

Test Plan (bench tick: s_tick every 4 clk; 1 bit = 64 clk):
- 8N1 frame 0xA5 with stop = 1 → one rx_done_tick pulse; dout = 0xA5; frame_err = 0; parity_err = 0.
- rx low for only 5 ticks, then high → stays in IDLE; no rx_done_tick; dout unchanged.
- Frame 0x3C with stop bit held low → rx_done_tick pulses; dout = 0x3C; frame_err = 1. A following good frame 0x01 → frame_err = 0.
- 0x00 followed immediately by 0xFF, with the next start bit right after the stop bit → two pulses, dout = 0x00 then 0xFF.
- reset asserted during data bit 3 of frame 0x77 → all outputs are 0 in the next cycle; no pulse. A following frame 0x5A → dout = 0x5A.
- With `UART_RX_PARITY_EN` and PARITY_ODD = 0: 0x07 with parity bit 0 → parity_err = 1; 0x07 with parity bit 1 → parity_err = 0.
